even_count_monitor: RTL and testbench

//   Receive-side checker for the even up-down counter outputs {A,B,C,D} (A = MSB) and its direction input Y.

---
 rtl/even_count_monitor.sv | 149 ++++++++++++++
 tb/tb_even_count_monitor.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/even_count_monitor.sv
// even_count_monitor: checks an even up/down counter steps by +/-2 mod 16.
// Optional saturating error counter built when MON_ERRCNT_EN is defined.
module even_count_monitor #(
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  input  logic             D,
  input  logic             Y,
  input  logic             en,
  output logic             locked,
  output logic             err,
  output logic             odd_seen,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    LOCKED,
    ERROR
  } state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);

  state_t     state_q, state_d;
  logic [3:0] prev_q, prev_d;
  logic       prev_y_q, prev_y_d;
  logic [3:0] good_cnt_q, good_cnt_d;
  logic       locked_q, locked_d;
  logic       err_q, err_d;
  logic       odd_q, odd_d;

  logic [3:0] cur;
  logic [3:0] exp_val;
  logic [3:0] cnt_inc;
  logic       good;

  // Step check: the counter moved by exactly 2 in the last commanded direction.
  always_comb begin
    cur     = {A, B, C, D};
    exp_val = prev_y_q ? prev_q + 4'd2 : prev_q - 4'd2;
    good    = (cur == exp_val) && !D;
    cnt_inc = (good_cnt_q == 4'hF) ? 4'hF : good_cnt_q + 4'd1;
  end

  // Next-state, sample history and registered outputs.
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    prev_y_d   = prev_y_q;
    good_cnt_d = good_cnt_q;
    locked_d   = locked_q;
    err_d      = 1'b0;
    odd_d      = odd_q;
    if (en) begin
      prev_d   = cur;
      prev_y_d = Y;
      odd_d    = odd_q | D;
      case (state_q)
        IDLE: begin
          state_d    = SEARCH;
          good_cnt_d = 4'd0;
        end
        SEARCH: begin
          if (good) begin
            good_cnt_d = cnt_inc;
            if (cnt_inc >= LOCK_N) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            good_cnt_d = 4'd0;
          end
        end
        LOCKED: begin
          if (!good) begin
            state_d  = ERROR;
            locked_d = 1'b0;
            err_d    = 1'b1;
          end
        end
        ERROR: begin
          state_d    = SEARCH;
          good_cnt_d = good ? 4'd1 : 4'd0;
        end
        default: begin
          state_d  = IDLE;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  // State and history registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      prev_q     <= 4'd0;
      prev_y_q   <= 1'b0;
      good_cnt_q <= 4'd0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      odd_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      prev_y_q   <= prev_y_d;
      good_cnt_q <= good_cnt_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      odd_q      <= odd_d;
    end
  end

  assign locked   = locked_q;
  assign err      = err_q;
  assign odd_seen = odd_q;

`ifdef MON_ERRCNT_EN
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  // Saturating tally of error pulses, counted on the edge the pulse appears.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  // Error counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_even_count_monitor.sv
// tb_even_count_monitor: directed scenarios plus random stimulus
// checked every cycle against a behavioural step model.
module tb_even_count_monitor;

  localparam int LOCK_CNT = 3;
  localparam int ERR_W    = 8;
  localparam int ECNT_MAX = (1 << ERR_W) - 1;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             A = 1'b0, B = 1'b0, C = 1'b0, D = 1'b0;
  logic             Y = 1'b0;
  logic             en = 1'b0;
  logic             locked, err, odd_seen;
  logic [ERR_W-1:0] err_count;

  int total = 0;
  int bad   = 0;
  bit cmp_on = 1'b0;

  even_count_monitor #(
    .LOCK_CNT(LOCK_CNT),
    .ERR_W(ERR_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .A(A),
    .B(B),
    .C(C),
    .D(D),
    .Y(Y),
    .en(en),
    .locked(locked),
    .err(err),
    .odd_seen(odd_seen),
    .err_count(err_count)
  );

  always #5 clock = ~clock;

  // Behavioural model: history of last sample, run length of good steps.
  bit seeded = 0;
  bit recovering = 0;
  int run = 0;
  int pv = 0;
  bit py = 0;
  bit m_locked = 0;
  bit m_err = 0;
  bit m_odd = 0;
  int m_ecnt = 0;

  function automatic int exp_ecnt();
`ifdef MON_ERRCNT_EN
    return m_ecnt;
`else
    return 0;
`endif
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      seeded = 0; recovering = 0; run = 0; pv = 0; py = 0;
      m_locked = 0; m_err = 0; m_odd = 0; m_ecnt = 0;
    end else begin
      m_err = 0;
      if (en) begin
        int cur;
        int step;
        bit ok;
        cur  = {A, B, C, D};
        step = py ? 2 : -2;
        ok   = (cur == ((pv + step + 16) % 16)) && !D;
        if (!seeded) begin
          seeded = 1;
          run = 0;
        end else if (m_locked) begin
          if (!ok) begin
            m_locked = 0;
            m_err = 1;
            recovering = 1;
            if (m_ecnt < ECNT_MAX) m_ecnt++;
          end
        end else if (recovering) begin
          recovering = 0;
          run = ok ? 1 : 0;
        end else begin
          run = ok ? run + 1 : 0;
          if (run >= LOCK_CNT) m_locked = 1;
        end
        if (D) m_odd = 1;
        pv = cur;
        py = Y;
      end
    end
  end

  // Per-cycle comparison of DUT against the model.
  always @(negedge clock) begin
    if (cmp_on) begin
      total++;
      if (locked !== m_locked || err !== m_err || odd_seen !== m_odd ||
          int'(err_count) != exp_ecnt()) begin
        bad++;
        $display("FAIL cycle t=%0t locked=%b/%b err=%b/%b odd=%b/%b ecnt=%0d/%0d",
                 $time, locked, m_locked, err, m_err, odd_seen, m_odd,
                 err_count, exp_ecnt());
      end
    end
  end

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  task automatic step(input logic [3:0] v, input logic y, input logic e);
    @(negedge clock);
    {A, B, C, D} = v;
    Y = y;
    en = e;
    @(posedge clock);
    #2;
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    #3 reset = 1'b1;
    #1;
    chk("rst_locked", int'(locked), 0);
    chk("rst_odd", int'(odd_seen), 0);
    chk("rst_ecnt", int'(err_count), 0);
    chk("rst_err", int'(err), 0);
    @(negedge clock);
    #3 reset = 1'b0;
  endtask

  logic [3:0] gv;
  logic       gy;
  logic [3:0] lastv;
  logic       lasty;

  initial begin
    #23 reset = 1'b0;
    cmp_on = 1'b1;
    chk("reset_locked", int'(locked), 0);
    chk("reset_odd", int'(odd_seen), 0);

    // 1: up run locks on the sample of 6
    step(4'd0, 1'b1, 1'b1);
    step(4'd2, 1'b1, 1'b1);
    step(4'd4, 1'b1, 1'b1);
    chk("t1_not_yet", int'(locked), 0);
    step(4'd6, 1'b1, 1'b1);
    chk("t1_lock", int'(locked), 1);
    chk("t1_lock_model", int'(m_locked), 1);
    step(4'd8, 1'b1, 1'b1);
    chk("t1_err", int'(err), 0);

    // 2: wrap 14 -> 0 -> 2 stays locked
    step(4'd10, 1'b1, 1'b1);
    step(4'd12, 1'b1, 1'b1);
    step(4'd14, 1'b1, 1'b1);
    step(4'd0, 1'b1, 1'b1);
    chk("t2_wrap_lock", int'(locked), 1);
    chk("t2_wrap_err", int'(err), 0);
    step(4'd2, 1'b1, 1'b1);

    // 3: skipped value errors, then relock after 3 good steps
    step(4'd4, 1'b1, 1'b1);
    step(4'd6, 1'b1, 1'b1);
    step(4'd8, 1'b1, 1'b1);
    step(4'd12, 1'b1, 1'b1);
    chk("t3_err", int'(err), 1);
    chk("t3_err_model", int'(m_err), 1);
    chk("t3_unlock", int'(locked), 0);
    step(4'd14, 1'b1, 1'b1);
    chk("t3_err_gone", int'(err), 0);
    step(4'd0, 1'b1, 1'b1);
    chk("t3_still_search", int'(locked), 0);
    step(4'd2, 1'b1, 1'b1);
    chk("t3_relock", int'(locked), 1);
`ifdef MON_ERRCNT_EN
    chk("t3_ecnt", int'(err_count), 1);
`else
    chk("t3_ecnt", int'(err_count), 0);
`endif

    // 4: direction reversal 6,8,6,4 is all good
    step(4'd4, 1'b1, 1'b1);
    step(4'd6, 1'b1, 1'b1);
    step(4'd8, 1'b0, 1'b1);
    step(4'd6, 1'b0, 1'b1);
    step(4'd4, 1'b0, 1'b1);
    chk("t4_lock", int'(locked), 1);
    chk("t4_err", int'(err), 0);

    // 5: odd value while searching is sticky, no err
    pulse_reset();
    step(4'd0, 1'b1, 1'b1);
    step(4'd2, 1'b1, 1'b1);
    step(4'd5, 1'b1, 1'b1);
    chk("t5_odd", int'(odd_seen), 1);
    chk("t5_odd_model", int'(m_odd), 1);
    chk("t5_err", int'(err), 0);
    step(4'd7, 1'b1, 1'b1);
    step(4'd8, 1'b1, 1'b1);
    step(4'd10, 1'b1, 1'b1);
    step(4'd12, 1'b1, 1'b1);
    chk("t5_no_lock", int'(locked), 0);
    step(4'd14, 1'b1, 1'b1);
    chk("t5_lock", int'(locked), 1);
    chk("t5_odd_sticky", int'(odd_seen), 1);

    // 6: en=0 holds everything, then reset clears
    for (int i = 0; i < 4; i++) begin
      step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
      chk("t6_hold_lock", int'(locked), 1);
      chk("t6_hold_err", int'(err), 0);
    end
    step(4'd0, 1'b1, 1'b1);
    chk("t6_resume", int'(locked), 1);
    pulse_reset();
    step(4'd6, 1'b0, 1'b1);
    chk("t6_seed_err", int'(err), 0);
    chk("t6_seed_lock", int'(locked), 0);

    // Random phase: mostly legal steps with faults, stalls and resets
    lastv = 4'd6;
    lasty = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) < 3) begin
        pulse_reset();
      end
      gy = ($urandom_range(0, 99) < 15) ? ~lasty : lasty;
      if ($urandom_range(0, 99) < 92) begin
        gv = lasty ? lastv + 4'd2 : lastv - 4'd2;
      end else begin
        gv = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 99) < 10) begin
        step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
      end else begin
        step(gv, gy, 1'b1);
        lastv = gv;
        lasty = gy;
      end
    end

    @(negedge clock);
    #1;
    cmp_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
